// File: rtl/iterative_divider_decode_if.sv
// Handshake bundle for the iterative divider: operand request side and result side.
interface iterative_divider_decode_if #(
  parameter int N = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider_decode.sv
// Restoring divider recovering F / D and F mod D, one quotient bit per clock, MSB first.
module iterative_divider_decode #(
  parameter int N = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  iterative_divider_decode_if.slave  bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  q_reg, q_next;
  logic [N:0]    r_reg, r_next;
  logic [N-1:0]  d_reg, d_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  quotient_reg, quotient_next;
  logic [N-1:0]  remainder_reg, remainder_next;
  logic          dbz_reg, dbz_next;

  logic [N:0]    r_shift;
  logic [N:0]    r_sub;
  logic          r_ge;
  logic [N:0]    r_step;
  logic [N-1:0]  q_step;

  // One restoring step: the N+1 bit partial remainder keeps the compare from wrapping.
  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
  assign r_sub   = r_shift - {1'b0, d_reg};
  assign r_ge    = (r_shift >= {1'b0, d_reg});
  assign r_step  = r_ge ? r_sub : r_shift;
  assign q_step  = {q_reg[N-2:0], r_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          d_next     = bus.divisor;
          q_next     = bus.dividend;
          r_next     = '0;
          count_next = '0;
          if (bus.divisor == '0) begin
            quotient_next  = '1;
            remainder_next = bus.dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        r_next     = r_step;
        q_next     = q_step;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(N - 1)) begin
          quotient_next  = q_step;
          remainder_next = r_step[N-1:0];
          dbz_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_iterative_divider_decode.sv
// Directed and randomized checks of the iterative divider against hand-computed results and / %.
module tb_iterative_divider_decode;
  localparam int N = 10;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iterative_divider_decode_if #(.N(N)) bus ();

  iterative_divider_decode #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the divider idle; runs one full operation.
  task automatic do_op(input int dvd, input int dvs, input int eq, input int er, input int edbz);
    int lat;
    int exp_lat;
    exp_lat = (dvs == 0) ? 0 : N;
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.dividend = 10'(dvd);
    bus.divisor  = 10'(dvs);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 10'($urandom);
    bus.divisor  = 10'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(edbz));
    check("in_ready_done", 32'(bus.in_ready), 0);
    $display("op dividend=%0d divisor=%0d -> q=%0d r=%0d dbz=%0d lat=%0d",
             dvd, dvs, bus.quotient, bus.remainder, bus.div_by_zero, lat);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_ack", 32'(bus.out_valid), 0);
    check("in_ready_after_ack", 32'(bus.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_in, n_out, cyc, seen;
    logic [9:0] sb_dvd[$];
    logic [9:0] sb_dvs[$];
    logic [9:0] a, b;
    int eq, er, ed;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dividend  = 10'd55;
    bus.divisor   = 10'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_quotient", 32'(bus.quotient), 0);
    check("rst_remainder", 32'(bus.remainder), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;

    do_op(1000, 7, 142, 6, 0);
    do_op(5, 9, 0, 5, 0);
    do_op(1023, 1, 1023, 0, 0);
    do_op(1023, 1023, 1, 0, 0);
    do_op(123, 0, 1023, 123, 1);
    do_op(0, 5, 0, 0, 0);
    do_op(512, 2, 256, 0, 0);

    // Backpressure: hold the result while a new request is waiting.
    bus.dividend = 10'd100;
    bus.divisor  = 10'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.dividend = 10'd999;
    bus.divisor  = 10'd4;
    repeat (N) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_quotient", 32'(bus.quotient), 33);
      check("bp_remainder", 32'(bus.remainder), 1);
      @(posedge clk); #1;
    end
    $display("op dividend=100 divisor=3 held 5 cycles -> q=%0d r=%0d", bus.quotient, bus.remainder);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    check("bp_quotient_kept", 32'(bus.quotient), 33);
    @(posedge clk); #1;
    check("bp_no_accept", 32'(bus.in_ready), 1);

    // Abort mid-run with reset.
    bus.dividend = 10'd1000;
    bus.divisor  = 10'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_quotient", 32'(bus.quotient), 0);
    check("abort_remainder", 32'(bus.remainder), 0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 0);
    $display("op dividend=1000 divisor=7 aborted by reset");
    do_op(200, 9, 22, 2, 0);

    // Random traffic against a / % reference with an in-order scoreboard.
    n_in = 0;
    n_out = 0;
    cyc = 0;
    while (n_out < 1000 && cyc < 60000) begin
      if (n_in < 1000) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = 10'($urandom);
        bus.divisor  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_dvd.push_back(bus.dividend);
        sb_dvs.push_back(bus.divisor);
        n_in++;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_dvd.size() == 0) begin
          check("rand_unexpected_output", 32'(1), 0);
        end else begin
          a = sb_dvd.pop_front();
          b = sb_dvs.pop_front();
          if (b == 0) begin
            eq = 1023; er = int'(a); ed = 1;
          end else begin
            eq = int'(a) / int'(b); er = int'(a) % int'(b); ed = 0;
          end
          check("rand_quotient", 32'(bus.quotient), 32'(eq));
          check("rand_remainder", 32'(bus.remainder), 32'(er));
          check("rand_dbz", 32'(bus.div_by_zero), 32'(ed));
          if (n_out % 100 == 0)
            $display("rand op %0d dividend=%0d divisor=%0d -> q=%0d r=%0d dbz=%0d",
                     n_out, a, b, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        n_out++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_outputs", 32'(n_out), 1000);
    check("rand_inputs", 32'(n_in), 1000);
    check("rand_scoreboard_empty", 32'(sb_dvd.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
